// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads instruction memory from a UART byte stream and holds the core in reset meanwhile
module imem_boot_loader #(
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 6,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [31:0]       pc_addr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [2:0] S_RUN     = 3'd0;
  localparam logic [2:0] S_HDR0    = 3'd1;
  localparam logic [2:0] S_HDR1    = 3'd2;
  localparam logic [2:0] S_BYTES   = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  localparam logic [ADDR_W:0] WC_ONE  = (ADDR_W+1)'(1);
  localparam logic [15:0]     DEPTH16 = 16'(DEPTH);

  logic [2:0]      state;
  logic [15:0]     n;
  logic [1:0]      byte_cnt;
  logic [ADDR_W:0] word_cnt;
  logic [23:0]     asm_lo;
  logic [TO_W-1:0] to_cnt;
  logic [15:0]     n_hdr;
  logic [15:0]     word_cnt16;
  logic            last_write;
  logic            loading;
  logic            timed_out;
  logic            pc_unused;

  assign mem_raddr  = pc_addr[ADDR_W+1:2];
  assign pc_unused  = ^{pc_addr[31:ADDR_W+2], pc_addr[1:0]};
  assign core_hold  = (state != S_RUN);
  assign load_done  = (state == S_RELEASE);
  assign load_err   = (state == S_ERR);

  assign n_hdr      = {rx_data, n[7:0]};
  assign word_cnt16 = {{(15-ADDR_W){1'b0}}, word_cnt};
  // The write cycle that brings word_cnt up to N ends the load.
  assign last_write = mem_we && (word_cnt16 == n);
  assign loading    = (state == S_HDR0) || (state == S_HDR1) || (state == S_BYTES);
  assign timed_out  = loading && !rx_valid && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      n         <= '0;
      byte_cnt  <= '0;
      word_cnt  <= '0;
      asm_lo    <= '0;
      to_cnt    <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (loading) to_cnt <= rx_valid ? '0 : to_cnt + TO_ONE;

      case (state)
        S_RUN, S_ERR: begin
          if (load_req) begin
            state    <= S_HDR0;
            word_cnt <= '0;
            byte_cnt <= '0;
            to_cnt   <= '0;
          end
        end
        S_HDR0: begin
          if (timed_out) state <= S_ERR;
          else if (rx_valid) begin
            n[7:0] <= rx_data;
            state  <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (timed_out) state <= S_ERR;
          else if (rx_valid) begin
            n[15:8] <= rx_data;
            if (n_hdr == 16'd0)       state <= S_RELEASE;
            else if (n_hdr > DEPTH16) state <= S_ERR;
            else                      state <= S_BYTES;
          end
        end
        S_BYTES: begin
          if (last_write) state <= S_RELEASE;
          else if (timed_out) state <= S_ERR;
          else if (rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: asm_lo[7:0]   <= rx_data;
              2'd1: asm_lo[15:8]  <= rx_data;
              2'd2: asm_lo[23:16] <= rx_data;
              default: begin
                mem_we    <= 1'b1;
                mem_waddr <= word_cnt[ADDR_W-1:0];
                mem_wdata <= {rx_data, asm_lo};
                word_cnt  <= word_cnt + WC_ONE;
              end
            endcase
          end
        end
        S_RELEASE: state <= S_RUN;
        default:   state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader
module tb_imem_boot_loader;
  localparam int DEPTH       = 64;
  localparam int ADDR_W      = 6;
  localparam int TIMEOUT_CYC = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_req;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [31:0]       pc_addr;
  logic [ADDR_W-1:0] mem_raddr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              core_hold;
  logic              load_done;
  logic              load_err;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [ADDR_W-1:0] wq_addr[$];
  logic [31:0]       wq_data[$];
  logic [31:0]       shadow[DEPTH];
  logic [31:0]       exp_words[$];

  always #5 clk = ~clk;

  imem_boot_loader #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .rx_valid(rx_valid),
    .rx_data(rx_data), .pc_addr(pc_addr), .mem_raddr(mem_raddr),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .load_done(load_done), .load_err(load_err)
  );

  // Write/done log, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wq_addr.push_back(mem_waddr);
      wq_data.push_back(mem_wdata);
      shadow[mem_waddr] = mem_wdata;
    end
    if (load_done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic req);
    rx_valid = 1'b1;
    rx_data  = b;
    load_req = req;
    step();
    rx_valid = 1'b0;
    load_req = 1'b0;
  endtask

  task automatic pulse_req();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    done_cnt = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (done_cnt != 0) break;
      step();
    end
    step();
    step();
  endtask

  // Starts a load with a junk byte on the load_req cycle (must be dropped),
  // then header and exp_words, optionally with stray load_req pulses.
  task automatic run_frame(input int n, input int max_gap, input bit extra);
    send_byte(8'($urandom), 1'b1);
    send_byte(8'(n), extra);
    send_byte(8'(n >> 8), 1'b0);
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 4; b++) begin
        repeat ($urandom_range(0, max_gap)) step();
        send_byte(8'(exp_words[w] >> (8 * b)), extra && ($urandom_range(0, 3) == 0));
      end
    end
  endtask

  task automatic test_reset();
    logic [ADDR_W-1:0] exp_ra;
    rst = 1'b1; load_req = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    pc_addr = 32'h0000_0008;
    step(); step();
    rst = 1'b0;
    checks++; if (mem_raddr !== 6'd2) begin failures++; $display("FAIL reset_raddr got=%0d exp=2", mem_raddr); end
    checks++; if (core_hold !== 1'b0) begin failures++; $display("FAIL reset_hold got=%b exp=0", core_hold); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", load_done); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", load_err); end
    for (int i = 0; i < 4; i++) begin
      pc_addr = $urandom;
      #1;
      exp_ra = ADDR_W'((pc_addr >> 2) % DEPTH);
      checks++;
      if (mem_raddr !== exp_ra) begin
        failures++; $display("FAIL raddr pc=%h got=%0d exp=%0d", pc_addr, mem_raddr, exp_ra);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] bytes [10];
    bytes = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    exp_words.delete();
    exp_words.push_back(32'h0010_0513);
    exp_words.push_back(32'h0020_0593);
    clear_log();
    checks++; if (core_hold !== 1'b0) begin failures++; $display("FAIL basic_hold_pre got=%b exp=0", core_hold); end
    pulse_req();
    checks++; if (core_hold !== 1'b1) begin failures++; $display("FAIL basic_hold_rise got=%b exp=1", core_hold); end
    for (int i = 0; i < 10; i++) send_byte(bytes[i], 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (load_done === 1'b1) break;
      step();
    end
    checks++; if (load_done !== 1'b1 || core_hold !== 1'b1) begin
      failures++; $display("FAIL basic_done done=%b hold=%b exp=1,1", load_done, core_hold);
    end
    step();
    checks++; if (core_hold !== 1'b0 || load_done !== 1'b0) begin
      failures++; $display("FAIL basic_release hold=%b done=%b exp=0,0", core_hold, load_done);
    end
    checks++; if (wq_addr.size() != 2) begin failures++; $display("FAIL basic_count got=%0d exp=2", wq_addr.size()); end
    for (int i = 0; i < wq_addr.size() && i < 2; i++) begin
      checks++;
      if (wq_addr[i] !== ADDR_W'(i) || wq_data[i] !== exp_words[i]) begin
        failures++; $display("FAIL basic_write%0d got=%0d:%h exp=%0d:%h", i, wq_addr[i], wq_data[i], i, exp_words[i]);
      end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_oversize();
    clear_log();
    pulse_req();
    send_byte(8'h41, 1'b0);
    send_byte(8'h00, 1'b0);
    step();
    checks++; if (load_err !== 1'b1 || core_hold !== 1'b1) begin
      failures++; $display("FAIL oversize_err err=%b hold=%b exp=1,1", load_err, core_hold);
    end
    repeat (5) step();
    checks++; if (wq_addr.size() != 0) begin failures++; $display("FAIL oversize_writes got=%0d exp=0", wq_addr.size()); end
    pulse_req();
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL oversize_clear got=%b exp=0", load_err); end
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_done();
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL empty_done got=%0d exp=1", done_cnt); end
    checks++; if (core_hold !== 1'b0 || wq_addr.size() != 0) begin
      failures++; $display("FAIL empty_run hold=%b writes=%0d exp=0,0", core_hold, wq_addr.size());
    end
  endtask

  task automatic test_timeout();
    clear_log();
    pulse_req();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
    for (int k = 1; k <= TIMEOUT_CYC; k++) begin
      step();
      if (k == TIMEOUT_CYC - 1) begin
        checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL timeout_early idle=%0d got=%b exp=0", k, load_err); end
      end
      if (k == TIMEOUT_CYC) begin
        checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL timeout_err idle=%0d got=%b exp=1", k, load_err); end
      end
    end
    checks++; if (wq_addr.size() != 0 || core_hold !== 1'b1) begin
      failures++; $display("FAIL timeout_state writes=%0d hold=%b exp=0,1", wq_addr.size(), core_hold);
    end
  endtask

  task automatic test_reset_midload();
    logic [31:0] w0;
    rst = 1'b1; step(); rst = 1'b0;
    clear_log();
    w0 = $urandom;
    pulse_req();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int b = 0; b < 4; b++) send_byte(8'(w0 >> (8 * b)), 1'b0);
    send_byte(8'($urandom), 1'b0);
    send_byte(8'($urandom), 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (core_hold !== 1'b0 || mem_we !== 1'b0 || load_err !== 1'b0 || load_done !== 1'b0) begin
      failures++; $display("FAIL midrst_outputs hold=%b we=%b err=%b done=%b exp=0", core_hold, mem_we, load_err, load_done);
    end
    send_byte(8'($urandom), 1'b0);
    send_byte(8'($urandom), 1'b0);
    repeat (10) step();
    checks++; if (wq_addr.size() != 1) begin failures++; $display("FAIL midrst_writes got=%0d exp=1", wq_addr.size()); end
    checks++; if (shadow[0] !== w0) begin failures++; $display("FAIL midrst_word0 got=%h exp=%h", shadow[0], w0); end
  endtask

  task automatic test_random_loads();
    int n;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 8);
      exp_words.delete();
      for (int i = 0; i < n; i++) exp_words.push_back($urandom);
      clear_log();
      run_frame(n, 3, 1'b1);
      wait_done();
      checks++; if (wq_addr.size() != n) begin failures++; $display("FAIL rand_count it=%0d got=%0d exp=%0d", it, wq_addr.size(), n); end
      for (int i = 0; i < wq_addr.size() && i < n; i++) begin
        checks++;
        if (wq_addr[i] !== ADDR_W'(i) || wq_data[i] !== exp_words[i]) begin
          failures++; $display("FAIL rand_write it=%0d i=%0d got=%0d:%h exp=%0d:%h", it, i, wq_addr[i], wq_data[i], i, exp_words[i]);
        end
      end
      checks++; if (done_cnt != 1 || core_hold !== 1'b0) begin
        failures++; $display("FAIL rand_done it=%0d done=%0d hold=%b exp=1,0", it, done_cnt, core_hold);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_words.delete();
    for (int i = 0; i < DEPTH; i++) exp_words.push_back($urandom);
    clear_log();
    run_frame(DEPTH, 0, 1'b1);
    wait_done();
    checks++; if (wq_addr.size() != DEPTH) begin failures++; $display("FAIL full_count got=%0d exp=%0d", wq_addr.size(), DEPTH); end
    for (int i = 0; i < wq_addr.size() && i < DEPTH; i++) begin
      checks++;
      if (wq_addr[i] !== ADDR_W'(i) || wq_data[i] !== exp_words[i]) begin
        failures++; $display("FAIL full_write i=%0d got=%0d:%h exp=%0d:%h", i, wq_addr[i], wq_data[i], i, exp_words[i]);
      end
    end
    checks++; if (done_cnt != 1 || core_hold !== 1'b0) begin
      failures++; $display("FAIL full_done done=%0d hold=%b exp=1,0", done_cnt, core_hold);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_oversize();
    test_timeout();
    test_reset_midload();
    test_random_loads();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sequences program loading into the 64-word instruction memory from a byte stream delivered by the UART receiver.
- Owns the memory's write port and holds the core in reset while a load is in progress.
- Muxes the fetch word address, so the core fetches normally whenever no load is active.
- Sits between the UART RX block, the instruction memory and the core's reset/PC.

Parameters:
DEPTH, 64, instruction memory depth in 32-bit words
ADDR_W, 6, word address width (log2 DEPTH)
TIMEOUT_CYC, 100000, max idle cycles between bytes during a load before abort

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous active-high reset
load_req  in  1  single-cycle pulse; starts a load; ignored unless in RUN or ERR
rx_valid  in  1  one-cycle strobe; rx_data valid
rx_data  in  8  received byte
pc_addr  in  32  core fetch byte address
mem_raddr  out  ADDR_W  instruction memory read word address
mem_we  out  1  instruction memory write enable
mem_waddr  out  ADDR_W  write word address
mem_wdata  out  32  write data
core_hold  out  1  holds core in reset while high
load_done  out  1  one-cycle pulse on successful completion
load_err  out  1  sticky error flag

Behaviour:
- Reset (any state, including mid-load):
  - state=RUN; all outputs 0; byte, word and timeout counters cleared.
  - No write is issued in the reset cycle. A partially assembled word is discarded.
- mem_raddr = pc_addr[ADDR_W+1:2] combinationally in every state. It is unused while core_hold=1.
- Frame format: 2-byte word count N (little-endian), followed by 4*N bytes. Each word is little-endian: first byte is [7:0], fourth byte is [31:24].
- States:
  - RUN: core_hold=0.
    - load_req -> HDR0.
    - On the transition, core_hold=1 from the next cycle, load_err cleared, word counter cleared.
  - HDR0: rx_valid -> latch N[7:0] -> HDR1.
  - HDR1: rx_valid -> latch N[15:8], then:
    - N==0 -> RELEASE.
    - N>DEPTH -> ERR.
    - else -> BYTES.
  - BYTES:
    - Each rx_valid shifts the byte into the assembly register at lane byte_cnt; byte_cnt increments mod 4.
    - On the 4th byte, the next cycle drives exactly one cycle of mem_we=1, mem_waddr=word_cnt, mem_wdata=assembled word. word_cnt then increments.
    - When word_cnt reaches N after that write -> RELEASE.
    - An rx_valid coinciding with the mem_we cycle is accepted (back-to-back bytes must be supported at 1 byte/cycle).
  - RELEASE: load_done=1 for one cycle, core_hold=1; next cycle -> RUN (core_hold=0). The core restarts from PC 0.
  - ERR: load_err=1 and core_hold=1 until the next load_req (-> HDR0) or rst. No writes are issued.
- Timeout:
  - In HDR0, HDR1 and BYTES, a counter reloads on each rx_valid and counts otherwise.
  - At TIMEOUT_CYC consecutive idle cycles -> ERR.
  - Memory words already written stay written.
- load_req while in HDR0, HDR1, BYTES or RELEASE is ignored. load_req and rx_valid in the same RUN cycle: the byte is dropped.
- rx_valid in RUN or ERR is ignored.
- mem_we is never asserted outside BYTES, at most once per 4 accepted bytes, and never with mem_waddr >= N.
- Widths: N is 16-bit; the compare against DEPTH is unsigned. word_cnt is ADDR_W+1 bits, so N==DEPTH terminates without wrap.

Test Plan:
- Reset then pc_addr=0x0000_0008 -> mem_raddr=2, core_hold=0, mem_we=0, load_done=0, load_err=0.
- load_req, bytes 02 00 13 05 10 00 93 05 20 00 at 1 byte/cycle:
  - mem_we pulses twice: addr0=0x0010_0513, addr1=0x0020_0593.
  - load_done pulses once; core_hold rises the cycle after load_req and falls the cycle after load_done.
- Header 41 00 (N=65) -> ERR, load_err=1, core_hold=1, no mem_we. A following load_req with header 00 00 -> load_err=0, load_done pulse, back to RUN.
- N=1 and 3 data bytes, then silence for TIMEOUT_CYC cycles (set TIMEOUT_CYC=16 in the bench) -> ERR, no mem_we.
- rst asserted after 6 of 8 data bytes -> next cycle core_hold=0, state RUN, no further mem_we; addr0 holds its written word.
- N=64 full load with back-to-back bytes -> 64 writes, addresses 0..63 in order, no wrap to 0, load_done once; extra load_req pulses mid-load have no effect.
